fpga_cfg_loader: RTL and testbench
==================================

Name: fpga_cfg_loader

Overview:
Configuration controller for the fpga fabric. It accepts a bitstream as byte-wide words over a valid/ready handshake and shifts them serially, MSB first, into the fabric configuration chain. It verifies an XOR checksum word that follows the payload. On a match it pulses a latch strobe and enables the fabric io; on a mismatch it flags an error and leaves the fabric disabled.

Parameters:
CHAIN_LEN, 1024, number of configuration bits in the fabric chain; must be a multiple of WORD_W.
WORD_W, 8, width of an input bitstream word.
CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
clk  input  1  single system clock; all logic on its rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request (re)configuration; sampled only in IDLE, DONE or ERR.
abort  input  1  cancel an in-progress load.
in_data  input  WORD_W  bitstream word.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts in_data this cycle.
cfg_shift  output  1  shift enable to the fabric configuration chain.
cfg_bit  output  1  serial configuration bit; valid when cfg_shift=1.
cfg_latch  output  1  one-cycle pulse that transfers the shadow chain to the active configuration.
fabric_en  output  1  fabric io enable; 1 only while a verified configuration is active.
busy  output  1  high in LOAD, SHIFT, CHK and LATCH.
done  output  1  high in DONE.
err  output  1  high in ERR.
bit_cnt  output  CNT_W  number of bits shifted since the last start.

Behaviour:
- Reset: the clock edge with rst=1 forces IDLE from any state, including mid-operation.
  - All outputs return to 0, including fabric_en.
  - bit_cnt, the checksum register and the shift register clear to 0.
  - Chain contents are undefined after reset; the fabric stays disabled.
- Handshake: a word transfers on a clock edge where in_valid=1 and in_ready=1.
  - in_ready is combinational from state only, never from in_valid.
  - in_data is ignored when no transfer occurs.
- States:
  - IDLE: in_ready=0. If start=1 -> LOAD; bit_cnt and checksum clear to 0.
  - LOAD: in_ready=1.
    - On transfer: sreg <= in_data; checksum <= checksum ^ in_data; -> SHIFT.
    - With no transfer, the block waits indefinitely.
  - SHIFT: in_ready=0. Each cycle:
    - cfg_shift=1 and cfg_bit=sreg[WORD_W-1].
    - sreg shifts left by one bit and bit_cnt increments.
    - After WORD_W cycles: if bit_cnt==CHAIN_LEN -> CHK, else -> LOAD.
    - Peak rate is WORD_W+1 cycles per word, since there is no overlap.
  - CHK: in_ready=1.
    - On transfer, in_data is compared against the checksum.
    - Equal -> LATCH. Unequal -> ERR.
  - LATCH: cfg_latch=1 for exactly one cycle -> DONE.
  - DONE: done=1, fabric_en=1. If start=1 -> LOAD; fabric_en drops to 0 on that same edge; counters clear.
  - ERR: err=1, fabric_en=0. If start=1 -> LOAD; counters clear.
- abort:
  - In LOAD, SHIFT or CHK: -> ERR on the next edge.
  - Abort has priority over a simultaneous transfer; that word is discarded and does not update the checksum.
  - Ignored in IDLE, LATCH, DONE and ERR.
- start: ignored while busy=1. rst has priority over start and abort.
- Serial output: cfg_shift pulses total exactly CHAIN_LEN per successful load. cfg_bit=0 whenever cfg_shift=0.
- bit_cnt: saturates at CHAIN_LEN and holds its value through CHK, LATCH, DONE and ERR until the next start.
- Arithmetic: the checksum is a WORD_W-bit XOR over all payload words. bit_cnt is unsigned, with no wrap possible within a load.

Decomposition:
- Package fpga_cfg_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, CHK, LATCH, DONE, ERR);
  - default CHAIN_LEN and WORD_W constants;
  - a checksum-width localparam.
- One sub-module, cfg_piso: WORD_W-bit parallel-load, MSB-first shift register.
  - Inputs: load, shift, d.
  - Outputs: q_msb and a bit-index terminal count.
- The top-level module holds the FSM, bit_cnt and the checksum.

Test Plan:
All scenarios use CHAIN_LEN=16 and WORD_W=8.
1. Nominal load: start, words 0xA5, 0x3C, checksum 0x99, in_valid held high -> cfg_bit stream 1010010100111100 over 16 cfg_shift pulses; one cfg_latch pulse; done=1, fabric_en=1, bit_cnt=16.
2. Bad checksum: same payload with checksum 0x98 -> err=1, no cfg_latch pulse, fabric_en=0; a following start with correct data reaches done=1.
3. Source stalls: in_valid low for 5 cycles before each word -> in_ready stays high in LOAD; bit stream is identical to scenario 1; no extra cfg_shift pulses.
4. Reset mid-SHIFT: assert rst at bit_cnt=11 -> next edge gives IDLE with all outputs 0; start again gives a clean 16-bit load.
5. Abort in CHK coincident with a checksum transfer -> ERR; checksum not compared; fabric_en=0. Abort in DONE -> ignored, done stays 1.
6. Reconfigure from DONE: start -> fabric_en=0 on that edge; new payload 0xFF, 0x00 with checksum 0xFF -> done with stream 1111111100000000.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared types and default sizing for the fabric configuration loader.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StChk,
        StLatch,
        StDone,
        StErr
    } cfg_state_e;

    localparam int unsigned CHAIN_LEN_DEF = 1024;
    localparam int unsigned WORD_W_DEF    = 8;
    localparam int unsigned CSUM_W        = WORD_W_DEF;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-load, MSB-first shift register with a bit-index terminal count.
module cfg_piso #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] d,
    output logic              q_msb,
    output logic              last
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] sreg_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            sreg_q <= d;
            idx_q  <= '0;
        end else if (shift) begin
            sreg_q <= sreg_q << 1;
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign q_msb = sreg_q[WORD_W-1];
    // High on the cycle that shifts out the final bit of the current word.
    assign last  = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: accepts words, shifts them serially into the fabric chain,
// verifies a trailing XOR checksum and enables the fabric on success.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_shift,
    output logic              cfg_bit,
    output logic              cfg_latch,
    output logic              fabric_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_cnt
);

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [WORD_W-1:0] csum_q, csum_d;
    logic              xfer, piso_load, piso_shift, piso_msb, piso_last;

    cfg_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .d     (in_data),
        .q_msb (piso_msb),
        .last  (piso_last)
    );

    assign in_ready = (state_q == StLoad) || (state_q == StChk);
    assign xfer     = in_valid && in_ready;
    assign cnt_inc  = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        csum_d     = csum_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        cfg_shift  = 1'b0;
        cfg_bit    = 1'b0;
        cfg_latch  = 1'b0;
        fabric_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
                    csum_d    = '0;
                end
            end
            StLoad: begin
                busy = 1'b1;
                // Abort wins over a coincident transfer; the word is dropped.
                if (abort) begin
                    state_d = StErr;
                end else if (xfer) begin
                    piso_load = 1'b1;
                    csum_d    = csum_q ^ in_data;
                    state_d   = StShift;
                end
            end
            StShift: begin
                busy       = 1'b1;
                cfg_shift  = 1'b1;
                cfg_bit    = piso_msb;
                piso_shift = 1'b1;
                if (bit_cnt_q != CNT_W'(CHAIN_LEN)) begin
                    bit_cnt_d = cnt_inc;
                end
                if (abort) begin
                    state_d = StErr;
                end else if (piso_last) begin
                    state_d = (cnt_inc == CNT_W'(CHAIN_LEN)) ? StChk : StLoad;
                end
            end
            StChk: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StErr;
                end else if (xfer) begin
                    state_d = (in_data == csum_q) ? StLatch : StErr;
                end
            end
            StLatch: begin
                busy      = 1'b1;
                cfg_latch = 1'b1;
                state_d   = StDone;
            end
            StDone, StErr: begin
                done      = (state_q == StDone);
                err       = (state_q == StErr);
                fabric_en = (state_q == StDone);
                if (start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
                    csum_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            csum_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            csum_q    <= csum_d;
        end
    end

    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader with a 16-bit chain and byte-wide words.
module tb_fpga_cfg_loader;

    logic       clk = 1'b0;
    logic       rst, start, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, cfg_shift, cfg_bit, cfg_latch, fabric_en, busy, done, err;
    logic [4:0] bit_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] hist = '0;
    int shift_total = 0;
    int latch_total = 0;
    int stray_bits = 0;
    int s0, l0;

    fpga_cfg_loader #(
        .CHAIN_LEN (16),
        .WORD_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_shift (cfg_shift),
        .cfg_bit   (cfg_bit),
        .cfg_latch (cfg_latch),
        .fabric_en (fabric_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // Records the serial stream and strobes seen by the fabric.
    always @(negedge clk) begin
        if (cfg_shift) begin
            hist        <= {hist[62:0], cfg_bit};
            shift_total <= shift_total + 1;
        end else if (cfg_bit) begin
            stray_bits <= stray_bits + 1;
        end
        if (cfg_latch) latch_total <= latch_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int stall);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(n < 100), 32'd1);
        in_data = 8'hEE;
        repeat (stall) begin
            check("stall_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done && !err && n < 50) begin
            tick();
            n++;
        end
        check("end_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic do_load(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] cs, input int stall);
        pulse_start();
        send_word(w0, stall);
        send_word(w1, stall);
        send_word(cs, stall);
        wait_end();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_fabric", 32'(fabric_en), 32'd0);
        check("rst_cnt", 32'(bit_cnt), 32'd0);
        check("rst_done_err", 32'({done, err, cfg_shift, cfg_latch}), 32'd0);

        // 1: nominal load
        s0 = shift_total; l0 = latch_total;
        do_load(8'hA5, 8'h3C, 8'h99, 0);
        check("s1_stream", 32'(hist[15:0]), 32'hA53C);
        check("s1_shifts", 32'(shift_total - s0), 32'd16);
        check("s1_latch", 32'(latch_total - l0), 32'd1);
        check("s1_done", 32'({done, fabric_en, err}), 32'b110);
        check("s1_cnt", 32'(bit_cnt), 32'd16);

        // 2: bad checksum then recovery
        l0 = latch_total;
        do_load(8'hA5, 8'h3C, 8'h98, 0);
        check("s2_err", 32'({err, done, fabric_en}), 32'b100);
        check("s2_latch", 32'(latch_total - l0), 32'd0);
        check("s2_cnt", 32'(bit_cnt), 32'd16);
        do_load(8'hA5, 8'h3C, 8'h99, 0);
        check("s2_recover", 32'({done, fabric_en}), 32'b11);

        // 3: stalled source
        s0 = shift_total; l0 = latch_total;
        do_load(8'hA5, 8'h3C, 8'h99, 5);
        check("s3_stream", 32'(hist[15:0]), 32'hA53C);
        check("s3_shifts", 32'(shift_total - s0), 32'd16);
        check("s3_latch", 32'(latch_total - l0), 32'd1);
        check("s3_done", 32'(done), 32'd1);

        // 4: reset mid-shift
        pulse_start();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        begin
            int n;
            n = 0;
            while (bit_cnt != 5'd11 && n < 50) begin
                tick();
                n++;
            end
            check("s4_reach11", 32'(bit_cnt), 32'd11);
        end
        check("s4_shifting", 32'(cfg_shift), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s4_outs", 32'({in_ready, cfg_shift, cfg_bit, cfg_latch, fabric_en, busy, done, err}),
              32'd0);
        check("s4_cnt", 32'(bit_cnt), 32'd0);
        tick();
        check("s4_idle", 32'(busy), 32'd0);
        s0 = shift_total;
        do_load(8'hA5, 8'h3C, 8'h99, 0);
        check("s4_stream", 32'(hist[15:0]), 32'hA53C);
        check("s4_shifts", 32'(shift_total - s0), 32'd16);
        check("s4_done", 32'(done), 32'd1);

        // 5: abort in CHK with a correct checksum on the bus
        l0 = latch_total;
        pulse_start();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        begin
            int n;
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
        end
        check("s5_chk_cnt", 32'(bit_cnt), 32'd16);
        in_valid = 1'b1; in_data = 8'h99; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        check("s5_err", 32'({err, done, fabric_en}), 32'b100);
        tick();
        check("s5_latch", 32'(latch_total - l0), 32'd0);
        do_load(8'hA5, 8'h3C, 8'h99, 0);
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        check("s5_abort_done", 32'({done, fabric_en, err}), 32'b110);

        // 6: reconfigure from DONE
        pulse_start();
        check("s6_fabric_drop", 32'({fabric_en, done, busy, in_ready}), 32'b0011);
        check("s6_cnt_clr", 32'(bit_cnt), 32'd0);
        s0 = shift_total;
        send_word(8'hFF, 0);
        send_word(8'h00, 0);
        send_word(8'hFF, 0);
        wait_end();
        check("s6_stream", 32'(hist[15:0]), 32'hFF00);
        check("s6_shifts", 32'(shift_total - s0), 32'd16);
        check("s6_done", 32'({done, fabric_en}), 32'b11);

        check("stray_bits", 32'(stray_bits), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
